spi_slave_regfile: RTL and testbench

- Parametrised successor to the TinyDDS SPI configuration slave: an SPI mode-0 slave driving a generic bank of NUM_REGS registers, each DATA_W bits wide.
- Adds input synchronisers, frame-length checking, per-register reset values, a write strobe, and register readback over MISO.
- Sits between the external SPI pins and the DDS core; the core consumes the flattened register bus.

---
 rtl/spi_slave_regfile_if.sv | 19 +
 rtl/spi_slave_regfile.sv | 131 +++++++++++++
 tb/tb_spi_slave_regfile.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle for the register-file slave: SCK, CS_n and MOSI driven by the host,
// MISO and its pad enable driven back by the slave.
interface spi_slave_regfile_if;
    logic spi_clock;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_clock, spi_cs_n, spi_mosi,
        input  spi_miso, spi_miso_oe
    );

    modport slave (
        input  spi_clock, spi_cs_n, spi_mosi,
        output spi_miso, spi_miso_oe
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave in front of a bank of NUM_REGS configuration registers.
// Frames are {R/W, addr, data} MSB first; writes commit on CS rise, reads stream out on MISO.
module spi_slave_regfile #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 28,
    parameter int NUM_REGS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_slave_regfile_if.slave           spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;

    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [DATA_W-1:0]  miso_sh;
    logic               miso_oe;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    // NOTE: every clocked block here uses non-blocking assignments so the synchroniser
    // chain shifts by exactly one stage per clk regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  spi.spi_clock};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi.spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_d;
    assign sck_fall = ~sck_s &  sck_d;
    assign cs_rise  =  cs_s  & ~cs_d;
    assign cs_fall  = ~cs_s  &  cs_d;

    // Header fields are taken from the value being shifted in, so the read word can be
    // fetched on the very SCK rise that completes the address.
    logic [FRAME_W-1:0] shift_nxt;
    logic               hdr_rw, hdr_hit, frm_rw, frm_hit;
    logic [ADDR_W-1:0]  hdr_addr, frm_addr;
    logic [IDX_W-1:0]   hdr_idx, frm_idx;
    logic [DATA_W-1:0]  frm_data;

    assign shift_nxt = {shreg[FRAME_W-2:0], mosi_s};
    assign hdr_rw    = shift_nxt[ADDR_W];
    assign hdr_addr  = shift_nxt[ADDR_W-1:0];
    assign hdr_idx   = hdr_addr[IDX_W-1:0];
    assign hdr_hit   = 32'(hdr_addr) < NUM_REGS;
    assign frm_rw    = shreg[FRAME_W-1];
    assign frm_addr  = shreg[FRAME_W-2 -: ADDR_W];
    assign frm_idx   = frm_addr[IDX_W-1:0];
    assign frm_hit   = 32'(frm_addr) < NUM_REGS;
    assign frm_data  = shreg[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            miso_sh   <= '0;
            miso_oe   <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            // NOTE: this bank is reset on purpose; its power-up contents are part of the
            // programming model, unlike a data RAM which would be left unreset.
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= RESET_VALUES[i*DATA_W +: DATA_W];
        end else begin
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;
            if (cs_fall) begin
                bit_cnt <= '0;
                shreg   <= '0;
                miso_sh <= '0;
                miso_oe <= 1'b1;
            end else if (cs_rise) begin
                miso_oe <= 1'b0;
                miso_sh <= '0;
                if (bit_cnt != CNT_W'(FRAME_W)) begin
                    frame_err <= 1'b1;
                end else if (!frm_rw && frm_hit) begin
                    regs[frm_idx] <= frm_data;
                    wr_pulse      <= 1'b1;
                    wr_addr       <= frm_addr;
                end
            end else if (!cs_s) begin
                if (sck_rise) begin
                    shreg <= shift_nxt;
                    if (bit_cnt != CNT_W'(FRAME_W + 1))
                        bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(ADDR_W) && hdr_rw)
                        miso_sh <= hdr_hit ? regs[hdr_idx] : '0;
                end else if (sck_fall && bit_cnt > CNT_W'(ADDR_W + 1)) begin
                    miso_sh <= {miso_sh[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

    assign spi.spi_miso    = miso_sh[DATA_W-1];
    assign spi.spi_miso_oe = miso_oe;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: writes and reads are queued when a frame is
// driven and retired when wr_pulse fires or the MISO word has been collected.
module tb_spi_slave_regfile;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 28;
    localparam int NUM_REGS = 8;
    localparam int SYNC     = 2;
    localparam int HP       = 8;
    localparam logic [NUM_REGS*DATA_W-1:0] RV = 224'hFF << (5 * DATA_W);

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk, rst_n;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic wr_pulse, frame_err;
    logic [ADDR_W-1:0] wr_addr;

    spi_slave_regfile_if sif();

    spi_slave_regfile #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
        .SYNC_STAGES(SYNC), .RESET_VALUES(RV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spi(sif),
        .regs_flat(regs_flat), .wr_pulse(wr_pulse),
        .wr_addr(wr_addr), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wr_t               exp_wr[$];
    logic [DATA_W-1:0] exp_rd[$];
    logic [DATA_W-1:0] model [NUM_REGS];
    int   vectors = 0, miscompares = 0, n_wr = 0, n_ferr = 0;
    logic prev_wr = 1'b0, prev_ferr = 1'b0;
    logic oe_ok;

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = model[i];
        return v;
    endfunction

    task automatic model_reset();
        logic [NUM_REGS*DATA_W-1:0] rv;
        rv = RV;
        for (int i = 0; i < NUM_REGS; i++) model[i] = rv[i*DATA_W +: DATA_W];
    endtask

    // Retire queued writes when the DUT strobes, and catch pulses wider than one cycle.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (wr_pulse === 1'b1) begin
            n_wr++;
            vectors++;
            if (exp_wr.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_wr_pulse got wr_addr=%0d expected no write", wr_addr);
            end else begin
                e = exp_wr.pop_front();
                if (wr_addr !== e.addr || regs_flat[32'(e.addr)*DATA_W +: DATA_W] !== e.data
                    || prev_wr !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wr_retire got addr=%0d data=%h prev=%b expected addr=%0d data=%h prev=0",
                             wr_addr, regs_flat[32'(e.addr)*DATA_W +: DATA_W], prev_wr, e.addr, e.data);
                end
            end
        end
        if (frame_err === 1'b1) begin
            n_ferr++;
            vectors++;
            if (prev_ferr !== 1'b0) begin
                miscompares++;
                $display("FAIL frame_err_width got two-cycle pulse expected one cycle");
            end
        end
        prev_wr   = wr_pulse;
        prev_ferr = frame_err;
    end

    task automatic chk(input string name, input logic [NUM_REGS*DATA_W-1:0] got,
                       input logic [NUM_REGS*DATA_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        sif.spi_cs_n = 1'b0;
        repeat (HP) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HP) @(negedge clk);
        sif.spi_cs_n = 1'b1;
        sif.spi_mosi = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic [63:0] f, output logic [63:0] m);
        m = '0;
        for (int i = n - 1; i >= 0; i--) begin
            sif.spi_mosi = f[i];
            repeat (HP) @(negedge clk);
            m[i]  = sif.spi_miso;
            oe_ok = oe_ok & sif.spi_miso_oe;
            sif.spi_clock = 1'b1;
            repeat (HP) @(negedge clk);
            sif.spi_clock = 1'b0;
        end
    endtask

    task automatic frame(input int n, input logic [63:0] f, output logic [63:0] m);
        cs_low();
        send_bits(n, f, m);
        cs_high();
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [63:0] m;
        wr_t e;
        e.addr = a;
        e.data = d;
        if (32'(a) < NUM_REGS) begin
            exp_wr.push_back(e);
            model[a[2:0]] = d;
        end
        frame(1 + ADDR_W + DATA_W, 64'({1'b0, a, d}), m);
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sif.spi_clock = 1'b0;
        sif.spi_cs_n  = 1'b1;
        sif.spi_mosi  = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        chk("reset_regs", regs_flat, RV);
        chk("reset_outs", 224'({sif.spi_miso_oe, sif.spi_miso, wr_pulse, frame_err, wr_addr}), '0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_regs", regs_flat, model_flat());
        chk("post_reset_pulses", 224'({n_wr[7:0], n_ferr[7:0], sif.spi_miso_oe}), '0);
    endtask

    task automatic test_write();
        logic [63:0] m;
        wr_t e;
        int lat, wr0;
        wr0 = n_wr;
        e.addr = 4'h1;
        e.data = 28'h1234567;
        exp_wr.push_back(e);
        model[1] = 28'h1234567;
        cs_low();
        send_bits(33, 64'({1'b0, 4'h1, 28'h1234567}), m);
        cs_high();
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (wr_pulse === 1'b1) begin
                lat = i;
                break;
            end
        end
        vectors++;
        if (lat < SYNC + 1 || lat > SYNC + 3) begin
            miscompares++;
            $display("FAIL write_latency got=%0d expected %0d..%0d", lat, SYNC + 1, SYNC + 3);
        end
        repeat (10) @(negedge clk);
        chk("write_regs", regs_flat, model_flat());
        chk("write_count", 224'(n_wr - wr0), 224'd1);
    endtask

    task automatic test_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [63:0] m;
        logic [DATA_W-1:0] e;
        int wr0;
        wr0 = n_wr;
        exp_rd.push_back(d);
        oe_ok = 1'b1;
        frame(33, 64'({1'b1, a, 28'h0}), m);
        repeat (10) @(negedge clk);
        e = exp_rd.pop_front();
        chk($sformatf("read_data_a%0d", a), 224'(m[DATA_W-1:0]), 224'(e));
        chk("read_oe_in_frame", 224'(oe_ok), 224'd1);
        chk("read_oe_after", 224'({sif.spi_miso_oe, sif.spi_miso}), '0);
        chk("read_no_side_effect", regs_flat, model_flat());
        chk("read_no_wr", 224'(n_wr - wr0), '0);
    endtask

    task automatic test_bad_len(input int n);
        logic [63:0] m, full, f;
        int wr0, fe0;
        wr0  = n_wr;
        fe0  = n_ferr;
        full = 64'({1'b0, 4'h2, 28'h5A5A5A5});
        f    = (n < 33) ? (full >> (33 - n)) : ((full << (n - 33)) | 64'h1);
        frame(n, f, m);
        repeat (12) @(negedge clk);
        chk($sformatf("badlen%0d_ferr", n), 224'(n_ferr - fe0), 224'd1);
        chk($sformatf("badlen%0d_nowr", n), 224'(n_wr - wr0), '0);
        chk($sformatf("badlen%0d_regs", n), regs_flat, model_flat());
    endtask

    task automatic test_bad_addr();
        int wr0, fe0;
        wr0 = n_wr;
        fe0 = n_ferr;
        write_reg(4'h9, 28'hFEDCBA9);
        chk("badaddr_pulses", 224'({n_wr - wr0, n_ferr - fe0}), '0);
        chk("badaddr_regs", regs_flat, model_flat());
        test_read(4'h9, 28'h0);
    endtask

    task automatic test_back_to_back();
        int wr0;
        wr0 = n_wr;
        write_reg(4'h0, 28'h0C0FFEE);
        write_reg(4'h7, 28'hFFFFFFF);
        chk("b2b_count", 224'(n_wr - wr0), 224'd2);
        chk("b2b_regs", regs_flat, model_flat());
        test_read(4'h7, 28'hFFFFFFF);
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] m, full;
        int wr0, fe0;
        full = 64'({1'b0, 4'h4, 28'hDEADBEE});
        cs_low();
        send_bits(10, full >> 23, m);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("midrst_regs", regs_flat, model_flat());
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        wr0 = n_wr;
        fe0 = n_ferr;
        send_bits(23, full, m);
        cs_high();
        repeat (12) @(negedge clk);
        chk("midrst_ferr", 224'(n_ferr - fe0), 224'd1);
        chk("midrst_nowr", 224'(n_wr - wr0), '0);
        chk("midrst_regs_after", regs_flat, model_flat());
        write_reg(4'h3, 28'hABC);
        chk("midrst_recover_wr", 224'(n_wr - wr0), 224'd1);
        chk("midrst_recover_regs", regs_flat, model_flat());
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(4'h1, 28'h1234567);
        test_read(4'h5, 28'h00000FF);
        test_bad_len(32);
        test_bad_len(34);
        test_bad_addr();
        test_back_to_back();
        test_reset_mid_frame();
        chk("queues_drained", 224'(exp_wr.size() + exp_rd.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
